// File: rtl/lsu.sv
// Load/store unit bridging RV32I byte/half/word accesses onto a word-only data memory.
// Sub-word stores are done as read-modify-write; sub-word loads are extracted and extended here.
module lsu #(
    parameter bit MISALIGN_CHK = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wd_i,
    output logic [31:0] rd_o,
    output logic        done_o,
    output logic        err_o,
    output logic        busy_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    output logic        mem_we_o,
    input  logic [31:0] mem_rd_i
);

    typedef enum logic [1:0] {IDLE, LD, RD, WR} state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wd_q, wd_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] rd_q, rd_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        illegal;
    logic        misal;
    logic [31:0] addr_al;

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] a,
                                            input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  extract = {{24{b[7]}}, b};
            3'b100:  extract = {24'h0, b};
            3'b001:  extract = {{16{h[15]}}, h};
            3'b101:  extract = {16'h0, h};
            default: extract = w;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] a,
                                          input logic half, input logic [31:0] d);
        logic [31:0] r;
        r = w;
        if (half) begin
            if (a[1]) r[31:16] = d[15:0];
            else      r[15:0]  = d[15:0];
        end else begin
            r[{a, 3'b000} +: 8] = d[7:0];
        end
        merge = r;
    endfunction

    always_comb begin
        illegal = we_i ? !(funct3_i inside {3'b000, 3'b001, 3'b010})
                       : !(funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        misal   = MISALIGN_CHK &&
                  (((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                   ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00)));
        addr_al = addr_i;
        // Without checking, the low bits are simply dropped to the natural alignment.
        if (!MISALIGN_CHK) begin
            if (funct3_i[1:0] == 2'b01) addr_al[0]   = 1'b0;
            if (funct3_i[1:0] == 2'b10) addr_al[1:0] = 2'b00;
        end
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wd_d     = wd_q;
        merge_d  = merge_q;
        rd_d     = rd_q;
        done_d   = 1'b0;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    we_d     = we_i;
                    funct3_d = funct3_i;
                    addr_d   = addr_al;
                    wd_d     = wd_i;
                    if (illegal || misal) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else if (!we_i) begin
                        state_d = LD;
                    end else if (funct3_i[1:0] == 2'b10) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            LD: begin
                rd_d    = extract(mem_rd_i, addr_q[1:0], funct3_q);
                done_d  = 1'b1;
                err_d   = 1'b0;
                state_d = IDLE;
            end
            RD: begin
                merge_d = merge(mem_rd_i, addr_q[1:0], funct3_q[0], wd_q);
                state_d = WR;
            end
            WR: begin
                done_d  = 1'b1;
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0;
            wd_q     <= 32'h0;
            merge_q  <= 32'h0;
            rd_q     <= 32'h0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wd_q     <= wd_d;
            merge_q  <= merge_d;
            rd_q     <= rd_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign rd_o       = rd_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign busy_o     = (state_q != IDLE);
    assign mem_addr_o = {addr_q[31:2], 2'b00};
    assign mem_wd_o   = (funct3_q[1:0] == 2'b10) ? wd_q : merge_q;
    assign mem_we_o   = (state_q == WR) && we_q && !rst_i;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: word memory model, directed spec cases, then random traffic against a
// byte-level reference model with a queue-based scoreboard.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [2:0]  funct3_i = 3'b000;
    logic [31:0] addr_i = 32'h0;
    logic [31:0] wd_i = 32'h0;
    logic [31:0] rd_o;
    logic        done_o, err_o, busy_o;
    logic [31:0] mem_addr_o, mem_wd_o;
    logic        mem_we_o;
    logic [31:0] mem_rd_i;

    lsu #(.MISALIGN_CHK(1'b1)) dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .funct3_i(funct3_i),
        .addr_i(addr_i), .wd_i(wd_i), .rd_o(rd_o), .done_o(done_o), .err_o(err_o),
        .busy_o(busy_o), .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o),
        .mem_we_o(mem_we_o), .mem_rd_i(mem_rd_i)
    );

    always #5 clk = ~clk;

    // data memory (64 words) driven by the DUT
    logic [31:0] dm [64];
    assign mem_rd_i = dm[mem_addr_o[7:2]];
    always @(posedge clk) if (mem_we_o) dm[mem_addr_o[7:2]] <= mem_wd_o;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // reference model state
    logic [31:0] ref_mem [64];
    logic [31:0] ref_rd = 32'h0;

    typedef struct {
        logic        err;
        logic [31:0] rd;
        int          cyc;
        int          wes;
    } exp_t;
    exp_t sb_q[$];

    function automatic int model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wd, output exp_t e);
        int sz, sh, lat;
        bit legal, mis;
        logic [31:0] w, v, mask;
        sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        mis = (sz == 2 && addr % 2 != 0) || (sz == 4 && addr % 4 != 0);
        sh = 8 * int'(addr % 4);
        w = ref_mem[addr[7:2]];
        e.wes = 0;
        if (!legal || mis) begin
            e.err = 1'b1;
            lat = 1;
        end else if (!we) begin
            v = w >> sh;
            if (sz == 1) begin
                v = v & 32'hFF;
                if (f3 == 3'd0 && v >= 32'h80) v = v | 32'hFFFFFF00;
            end else if (sz == 2) begin
                v = v & 32'hFFFF;
                if (f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF0000;
            end
            ref_rd = v;
            e.err = 1'b0;
            lat = 2;
        end else begin
            mask = (sz == 4) ? 32'hFFFFFFFF : (((32'h1 << (8 * sz)) - 1) << sh);
            ref_mem[addr[7:2]] = (w & ~mask) | ((wd << sh) & mask);
            e.err = 1'b0;
            e.wes = 1;
            lat = (sz == 4) ? 2 : 3;
        end
        e.rd = ref_rd;
        return lat;
    endfunction

    // scoreboard monitor
    int we_cnt = 0;
    always @(negedge clk) begin
        exp_t e;
        if (mem_we_o) we_cnt++;
        if (done_o) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_done: got done_o=1 expected no completion (cyc %0d)", cyc);
            end else begin
                e = sb_q.pop_front();
                check("err_o", {31'h0, err_o}, {31'h0, e.err});
                check("rd_o", rd_o, e.rd);
                check("done_latency_cycle", cyc, e.cyc);
                check("mem_we_count", we_cnt, e.wes);
            end
            we_cnt = 0;
        end
    end

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input bit poke);
        exp_t e;
        int lat;
        lat = model(we, f3, addr, wd, e);
        e.cyc = cyc + lat;
        sb_q.push_back(e);
        req_i = 1'b1; we_i = we; funct3_i = f3; addr_i = addr; wd_i = wd;
        @(negedge clk);
        req_i = 1'b0;
        if (poke && lat > 1) begin
            req_i = 1'b1; we_i = $urandom_range(0, 1); funct3_i = 3'($urandom_range(0, 7));
            addr_i = 32'($urandom_range(0, 255)); wd_i = $urandom;
            @(negedge clk);
            req_i = 1'b0;
        end
        for (int i = 0; i < 8 && !done_o; i++) @(negedge clk);
        if (!done_o) begin
            n_chk++;
            $display("FAIL done_timeout: got no done_o expected done within 8 cycles");
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            dm[i] = 32'($urandom);
            ref_mem[i] = dm[i];
        end
        dm[4] = 32'h80817F01;
        ref_mem[4] = 32'h80817F01;

        repeat (3) @(negedge clk);
        check("reset_done", {31'h0, done_o}, 32'h0);
        check("reset_err", {31'h0, err_o}, 32'h0);
        check("reset_rd", rd_o, 32'h0);
        check("reset_busy", {31'h0, busy_o}, 32'h0);
        check("reset_mem_we", {31'h0, mem_we_o}, 32'h0);
        rst_i = 1'b0;
        @(negedge clk);

        issue(0, 3'b000, 32'h10, 0, 0); check("LB_0x10", rd_o, 32'h00000001);
        issue(0, 3'b000, 32'h13, 0, 0); check("LB_0x13", rd_o, 32'hFFFFFF80);
        issue(0, 3'b100, 32'h13, 0, 0); check("LBU_0x13", rd_o, 32'h00000080);
        issue(0, 3'b001, 32'h12, 0, 1); check("LH_0x12", rd_o, 32'hFFFF8081);
        issue(0, 3'b101, 32'h12, 0, 0); check("LHU_0x12", rd_o, 32'h00008081);
        issue(0, 3'b010, 32'h10, 0, 0); check("LW_0x10", rd_o, 32'h80817F01);
        issue(1, 3'b000, 32'h11, 32'h123456AB, 0); check("SB_dm", dm[4], 32'h8081AB01);
        issue(1, 3'b001, 32'h12, 32'h0000BEEF, 1); check("SH_dm", dm[4], 32'hBEEFAB01);
        issue(1, 3'b010, 32'h20, 32'hDEADBEEF, 0); check("SW_dm", dm[8], 32'hDEADBEEF);
        issue(0, 3'b010, 32'h20, 0, 0); check("LW_readback", rd_o, 32'hDEADBEEF);
        issue(0, 3'b010, 32'h12, 0, 0); check("LW_mis_rd_kept", rd_o, 32'hDEADBEEF);
        issue(1, 3'b001, 32'h11, 32'h5555, 0);
        issue(0, 3'b011, 32'h10, 0, 0); check("f3_011_rd_kept", rd_o, 32'hDEADBEEF);
        check("err_dm_unchanged", dm[4], 32'hBEEFAB01);

        // reset asserted during the read phase of a halfword store
        req_i = 1'b1; we_i = 1'b1; funct3_i = 3'b001; addr_i = 32'h12; wd_i = 32'h0000CAFE;
        @(negedge clk);
        req_i = 1'b0;
        rst_i = 1'b1;
        check("rst_mid_mem_we", {31'h0, mem_we_o}, 32'h0);
        @(negedge clk);
        check("rst_mid_busy", {31'h0, busy_o}, 32'h0);
        check("rst_mid_mem_we2", {31'h0, mem_we_o}, 32'h0);
        rst_i = 1'b0;
        ref_rd = 32'h0;
        @(negedge clk);
        check("rst_mid_done", {31'h0, done_o}, 32'h0);
        check("rst_mid_mem_we3", {31'h0, mem_we_o}, 32'h0);
        check("rst_mid_dm", dm[4], 32'hBEEFAB01);

        for (int n = 0; n < 300; n++) begin
            logic [2:0] f3;
            logic we;
            we = 1'($urandom_range(0, 1));
            f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7))
                 : (we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 4)));
            if (!we && f3 == 3'd3) f3 = 3'd5;
            issue(we, f3, 32'($urandom_range(0, 255)), $urandom, 1'($urandom_range(0, 1)));
        end
        repeat (3) @(negedge clk);

        for (int i = 0; i < 64; i++) check("dm_final", dm[i], ref_mem[i]);
        check("scoreboard_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1);
    end

endmodule
